// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU operand-issue / writeback stage.
//   - Widths: DATA_W (operand/result), REG_W (register index), NREG.
//   - ALU opcode constants; opcodes above ALU_LAST_LEGAL are illegal.
//   - ex_reg_t: contents of the execute pipeline register.
//   - select_operand: register-0 / forwarding / register-file mux.
package alu_issue_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int NREG   = 32;
  localparam int OP_W   = 4;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t ALU_MUL        = 4'd0;
  localparam op_t ALU_RSUB       = 4'd1;
  localparam op_t ALU_NOR        = 4'd2;
  localparam op_t ALU_MADD       = 4'd3;
  localparam op_t ALU_MSUB       = 4'd4;
  localparam op_t ALU_SUB3       = 4'd5;
  localparam op_t ALU_ADD        = 4'd6;
  localparam op_t ALU_ADD23      = 4'd7;
  localparam op_t ALU_SLL        = 4'd8;
  localparam op_t ALU_SRL        = 4'd9;
  localparam op_t ALU_SRA        = 4'd10;
  localparam op_t ALU_ADDSLL     = 4'd11;
  localparam op_t ALU_ADDSRL     = 4'd12;
  localparam op_t ALU_LAST_LEGAL = 4'd12;

  typedef struct packed {
    logic              valid;
    op_t               op;
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [DATA_W-1:0] in3;
    logic [REG_W-1:0]  rd;
    logic              wen;
    logic              err;
  } ex_reg_t;

  // Register 0 is hard zero. Otherwise the instruction in execute, if it
  // will write this register, supplies its result ahead of the register file.
  function automatic logic [DATA_W-1:0] select_operand(
    input logic [REG_W-1:0]  r,
    input logic [DATA_W-1:0] rf_val,
    input ex_reg_t           ex,
    input logic [DATA_W-1:0] fwd_val
  );
    if (r == '0) begin
      return '0;
    end else if (ex.valid && ex.wen && (ex.rd == r)) begin
      return fwd_val;
    end else begin
      return rf_val;
    end
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue and result channels of the ALU issue stage.
//   Issue channel  : in_valid/in_ready, in_op, in_rs/in_rt/in_ru, in_rd, in_wen.
//   Result channel : res_valid/res_ready, res_data, res_rd, res_err.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. A producer holding valid keeps its payload stable until the transfer;
// ready may depend combinationally on the consumer's own state and on the
// downstream ready, never on the producer's valid.
// master = instruction source / result sink, slave = the issue stage.
interface alu_issue_stage_if;
  import alu_issue_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  op_t               in_op;
  logic [REG_W-1:0]  in_rs;
  logic [REG_W-1:0]  in_rt;
  logic [REG_W-1:0]  in_ru;
  logic [REG_W-1:0]  in_rd;
  logic              in_wen;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [REG_W-1:0]  res_rd;
  logic              res_err;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_ru, in_rd, in_wen, res_ready,
    input  in_ready, res_valid, res_data, res_rd, res_err
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_ru, in_rd, in_wen, res_ready,
    output in_ready, res_valid, res_data, res_rd, res_err
  );

endinterface

// File: rtl/alu_regfile.sv
// 32 x 32 register file for the ALU issue stage.
//   clk, rst        : clock, asynchronous active-high reset (clears all entries)
//   ra1..ra3        : read addresses, combinational read data on rd1..rd3
//   we, wa, wd      : single write port; writes to register 0 are dropped
// Register 0 always reads zero.
module alu_regfile
  import alu_issue_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  ra1,
  input  logic [REG_W-1:0]  ra2,
  input  logic [REG_W-1:0]  ra3,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rd3,
  input  logic              we,
  input  logic [REG_W-1:0]  wa,
  input  logic [DATA_W-1:0] wd
);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];
  assign rd3 = (ra3 == '0) ? '0 : regs[ra3];

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue and writeback stage in front of a combinational ALU.
//   clk, rst          : clock, asynchronous active-high reset
//   io (slave)        : issue channel in, result channel out
//   alu_in1..alu_in3  : ALU operands, straight from the execute register
//   alu_op            : ALU opcode, straight from the execute register
//   alu_out           : ALU result (combinational from alu_*)
// Issue reads three operands (with forwarding from execute) and loads the
// execute register; the result retires on the result handshake, which is
// also when it is written back to the register file.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  alu_issue_stage_if.slave  io,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [DATA_W-1:0] alu_in3,
  output op_t               alu_op,
  input  logic [DATA_W-1:0] alu_out
);

  ex_reg_t           ex_q;
  logic              accept;
  logic              retire;
  logic              illegal;
  logic              rf_we;
  logic [DATA_W-1:0] rf_rd1, rf_rd2, rf_rd3;
  logic [DATA_W-1:0] op1, op2, op3;

  // Execute register drains on the same edge it refills, so issue only
  // stalls while a result is held by downstream.
  assign io.in_ready = !ex_q.valid || io.res_ready;
  assign accept      = io.in_valid && io.in_ready;
  assign retire      = ex_q.valid && io.res_ready;
  assign illegal     = io.in_op > ALU_LAST_LEGAL;

  alu_regfile u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (io.in_rs),
    .ra2 (io.in_rt),
    .ra3 (io.in_ru),
    .rd1 (rf_rd1),
    .rd2 (rf_rd2),
    .rd3 (rf_rd3),
    .we  (rf_we),
    .wa  (ex_q.rd),
    .wd  (alu_out)
  );

  // The execute register is the only register-file writer, so forwarding
  // from it covers every read-after-write hazard with no stall.
  always_comb begin
    op1 = select_operand(io.in_rs, rf_rd1, ex_q, alu_out);
    op2 = select_operand(io.in_rt, rf_rd2, ex_q, alu_out);
    op3 = select_operand(io.in_ru, rf_rd3, ex_q, alu_out);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '0;
    end else if (accept) begin
      ex_q.valid <= 1'b1;
      // Illegal opcodes still flow through as a harmless ADD, flagged and
      // with the write suppressed.
      ex_q.op    <= illegal ? ALU_ADD : io.in_op;
      ex_q.in1   <= op1;
      ex_q.in2   <= op2;
      ex_q.in3   <= op3;
      ex_q.rd    <= io.in_rd;
      ex_q.wen   <= io.in_wen && !illegal;
      ex_q.err   <= illegal;
    end else if (retire) begin
      ex_q.valid <= 1'b0;
    end
  end

  assign rf_we = retire && ex_q.wen && !ex_q.err && (ex_q.rd != '0);

  assign alu_in1      = ex_q.in1;
  assign alu_in2      = ex_q.in2;
  assign alu_in3      = ex_q.in3;
  assign alu_op       = ex_q.op;
  assign io.res_valid = ex_q.valid;
  assign io.res_data  = alu_out;
  assign io.res_rd    = ex_q.rd;
  assign io.res_err   = ex_q.err;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage with a behavioural ALU alongside it. Expected
// results come from an architectural register model updated in issue order.
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  localparam int SB_W = 1 + REG_W + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_stage_if io ();
  logic [DATA_W-1:0] alu_in1, alu_in2, alu_in3, alu_out;
  op_t               alu_op;

  alu_issue_stage dut (
    .clk     (clk),
    .rst     (rst),
    .io      (io),
    .alu_in1 (alu_in1),
    .alu_in2 (alu_in2),
    .alu_in3 (alu_in3),
    .alu_op  (alu_op),
    .alu_out (alu_out)
  );

  function automatic logic [DATA_W-1:0] alu_f(input op_t op,
      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
      input logic [DATA_W-1:0] c);
    case (op)
      ALU_MUL:    return a * b;
      ALU_RSUB:   return b - a;
      ALU_NOR:    return ~(a | b);
      ALU_MADD:   return a * b + c;
      ALU_MSUB:   return a * b - c;
      ALU_SUB3:   return a - b - c;
      ALU_ADD:    return a + b;
      ALU_ADD23:  return a + b + c;
      ALU_SLL:    return a << b[4:0];
      ALU_SRL:    return a >> b[4:0];
      ALU_SRA:    return $unsigned($signed(a) >>> b[4:0]);
      ALU_ADDSLL: return (a + b) << c[4:0];
      ALU_ADDSRL: return (a + b) >> c[4:0];
      default:    return '0;
    endcase
  endfunction

  assign alu_out = alu_f(alu_op, alu_in1, alu_in2, alu_in3);

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [SB_W-1:0]   exp_q[$];
  logic [DATA_W-1:0] model_rf [NREG];
  int   last_wait;
  logic release_on_stall = 1'b0;

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) model_rf[i] = '0;
    exp_q.delete();
  endtask

  // Retirement monitor: a result handshake seen at the falling edge completes
  // on the next rising edge.
  always @(negedge clk) begin
    logic [SB_W-1:0] e;
    if (!rst && io.res_valid && io.res_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got err=%0d rd=%0d data=%h required no result",
                 io.res_err, io.res_rd, io.res_data);
      end else begin
        e = exp_q.pop_front();
        if ({io.res_err, io.res_rd, io.res_data} !== e) begin
          bad++;
          $display("FAIL sb_result got err=%0d rd=%0d data=%h required err=%0d rd=%0d data=%h",
                   io.res_err, io.res_rd, io.res_data,
                   e[SB_W-1], e[DATA_W +: REG_W], e[DATA_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic issue(input op_t op, input logic [REG_W-1:0] rs,
      input logic [REG_W-1:0] rt, input logic [REG_W-1:0] ru,
      input logic [REG_W-1:0] rd, input logic wen);
    int waited;
    logic err;
    logic [DATA_W-1:0] d;
    waited = 0;
    io.in_op = op; io.in_rs = rs; io.in_rt = rt; io.in_ru = ru;
    io.in_rd = rd; io.in_wen = wen; io.in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (io.in_ready) break;
      waited++;
      if (waited > 50) begin
        total++; bad++;
        $display("FAIL issue_timeout got in_ready=0 for %0d cycles required 1", waited);
        io.in_valid = 1'b0;
        last_wait = waited;
        return;
      end
      @(posedge clk); #1;
      if (release_on_stall) io.res_ready = 1'b1;
    end
    last_wait = waited;
    err = op > ALU_LAST_LEGAL;
    d = alu_f(err ? ALU_ADD : op, model_rf[rs], model_rf[rt], model_rf[ru]);
    exp_q.push_back({err, rd, d});
    if (wen && !err && rd != '0) model_rf[rd] = d;
    @(posedge clk); #1;
    io.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout got pending=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    io.in_valid = 1'b0; io.res_ready = 1'b1;
    io.in_op = op_t'($urandom_range(0, 15));
    io.in_rs = 5'($urandom_range(0, 31)); io.in_rt = 5'($urandom_range(0, 31));
    io.in_ru = 5'($urandom_range(0, 31)); io.in_rd = 5'($urandom_range(0, 31));
    io.in_wen = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (io.in_ready !== 1'b1)  begin bad++; $display("FAIL rst_in_ready got %b required 1", io.in_ready); end
    total++; if (io.res_valid !== 1'b0) begin bad++; $display("FAIL rst_res_valid got %b required 0", io.res_valid); end
    total++; if (io.res_err !== 1'b0)   begin bad++; $display("FAIL rst_res_err got %b required 0", io.res_err); end
    total++; if (io.res_rd !== 5'd0)    begin bad++; $display("FAIL rst_res_rd got %0d required 0", io.res_rd); end
    total++; if (alu_in1 !== 32'd0)     begin bad++; $display("FAIL rst_alu_in1 got %h required 0", alu_in1); end
    total++; if (alu_in2 !== 32'd0)     begin bad++; $display("FAIL rst_alu_in2 got %h required 0", alu_in2); end
    total++; if (alu_in3 !== 32'd0)     begin bad++; $display("FAIL rst_alu_in3 got %h required 0", alu_in3); end
    total++; if (alu_op !== 4'd0)       begin bad++; $display("FAIL rst_alu_op got %0d required 0", alu_op); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_ops();
    issue(ALU_ADD, 5'd0, 5'd0, 5'd0, 5'd1, 1'b1);
    total++; if (io.res_valid !== 1'b1) begin bad++; $display("FAIL first_res_valid got %b required 1", io.res_valid); end
    total++; if (alu_op !== ALU_ADD)    begin bad++; $display("FAIL first_alu_op got %0d required 6", alu_op); end
    issue(ALU_ADD23, 5'd31, 5'd30, 5'd29, 5'd2, 1'b1);
    drain();
    issue(ALU_ADD, 5'd2, 5'd0, 5'd0, 5'd0, 1'b0);
    drain();
  endtask

  task automatic test_preload_sub3();
    issue(ALU_NOR,   5'd0,  5'd0,  5'd0,  5'd14, 1'b1); // -1
    issue(ALU_RSUB,  5'd14, 5'd0,  5'd0,  5'd15, 1'b1); // 1
    issue(ALU_ADD,   5'd15, 5'd15, 5'd0,  5'd17, 1'b1); // 2
    issue(ALU_ADD,   5'd17, 5'd17, 5'd0,  5'd18, 1'b1); // 4
    issue(ALU_ADD23, 5'd18, 5'd17, 5'd15, 5'd3,  1'b1); // 7
    issue(ALU_ADD,   5'd18, 5'd15, 5'd0,  5'd4,  1'b1); // 5
    drain();
    issue(ALU_SUB3,  5'd3,  5'd4,  5'd0,  5'd5,  1'b1);
    total++; if (alu_in1 !== 32'd7) begin bad++; $display("FAIL sub3_in1 got %0d required 7", alu_in1); end
    total++; if (alu_in2 !== 32'd5) begin bad++; $display("FAIL sub3_in2 got %0d required 5", alu_in2); end
    total++; if (alu_out !== 32'd2) begin bad++; $display("FAIL sub3_result got %0d required 2", alu_out); end
    drain();
    issue(ALU_ADD,   5'd5,  5'd0,  5'd0,  5'd21, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back();
    issue(ALU_ADD, 5'd3, 5'd4, 5'd0, 5'd6, 1'b1);
    issue(ALU_ADD, 5'd6, 5'd6, 5'd0, 5'd7, 1'b1);
    total++; if (last_wait !== 0)    begin bad++; $display("FAIL b2b_bubble got %0d stall cycles required 0", last_wait); end
    total++; if (alu_in1 !== 32'd12) begin bad++; $display("FAIL b2b_fwd_in1 got %0d required 12", alu_in1); end
    total++; if (alu_out !== 32'd24) begin bad++; $display("FAIL b2b_result got %0d required 24", alu_out); end
    drain();
  endtask

  task automatic test_stall();
    io.res_ready = 1'b0;
    issue(ALU_ADD, 5'd3, 5'd4, 5'd0, 5'd9, 1'b1);
    // A second instruction waits; it must not be taken while stalled.
    io.in_op = ALU_ADD; io.in_rs = 5'd9; io.in_rt = 5'd0; io.in_ru = 5'd0;
    io.in_rd = 5'd10; io.in_wen = 1'b1; io.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (io.in_ready !== 1'b0)  begin bad++; $display("FAIL stall_in_ready c%0d got %b required 0", i, io.in_ready); end
      total++; if (io.res_valid !== 1'b1) begin bad++; $display("FAIL stall_res_valid c%0d got %b required 1", i, io.res_valid); end
      total++; if (alu_in1 !== 32'd7 || alu_in2 !== 32'd5 || io.res_rd !== 5'd9 || alu_op !== ALU_ADD) begin
        bad++; $display("FAIL stall_hold c%0d got in1=%0d in2=%0d rd=%0d op=%0d required 7 5 9 6",
                        i, alu_in1, alu_in2, io.res_rd, alu_op);
      end
      @(posedge clk); #1;
    end
    io.in_valid = 1'b0;
    io.res_ready = 1'b1;
    drain();
    issue(ALU_ADD, 5'd9, 5'd0, 5'd0, 5'd11, 1'b0);
    total++; if (alu_in1 !== 32'd12) begin bad++; $display("FAIL stall_writeback got %0d required 12", alu_in1); end
    drain();
  endtask

  task automatic test_illegal_and_r0();
    issue(4'hE, 5'd3, 5'd4, 5'd0, 5'd8, 1'b1);
    total++; if (alu_op !== ALU_ADD)    begin bad++; $display("FAIL illegal_alu_op got %0d required 6", alu_op); end
    total++; if (io.res_err !== 1'b1)   begin bad++; $display("FAIL illegal_res_err got %b required 1", io.res_err); end
    drain();
    issue(ALU_ADD, 5'd8, 5'd0, 5'd0, 5'd22, 1'b0);
    total++; if (alu_in1 !== 32'd0) begin bad++; $display("FAIL illegal_no_write got r8=%0d required 0", alu_in1); end
    drain();
    issue(ALU_ADD, 5'd3, 5'd0, 5'd0, 5'd0, 1'b1);
    issue(ALU_ADD, 5'd0, 5'd0, 5'd0, 5'd23, 1'b1);
    total++; if (alu_in1 !== 32'd0) begin bad++; $display("FAIL r0_no_fwd got %0d required 0", alu_in1); end
    drain();
  endtask

  task automatic test_random();
    release_on_stall = 1'b1;
    for (int i = 0; i < 40; i++) begin
      io.res_ready = ($urandom_range(0, 3) != 0);
      issue(op_t'($urandom_range(0, 15)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    io.res_ready = 1'b1;
    release_on_stall = 1'b0;
    drain();
    for (int r = 1; r < 8; r++) begin
      issue(ALU_ADD, 5'(r), 5'd0, 5'd0, 5'd0, 1'b0);
    end
    drain();
  endtask

  task automatic test_reset_mid_op();
    io.res_ready = 1'b0;
    issue(ALU_ADD, 5'd3, 5'd4, 5'd0, 5'd13, 1'b1);
    @(negedge clk);
    total++; if (io.res_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid got %b required 1", io.res_valid); end
    rst = 1'b1;
    #1;
    total++; if (io.res_valid !== 1'b0) begin bad++; $display("FAIL midrst_res_valid got %b required 0", io.res_valid); end
    total++; if (io.in_ready !== 1'b1)  begin bad++; $display("FAIL midrst_in_ready got %b required 1", io.in_ready); end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    io.res_ready = 1'b1;
    @(posedge clk); #1;
    issue(ALU_ADD, 5'd13, 5'd3, 5'd0, 5'd24, 1'b0);
    total++; if (alu_in1 !== 32'd0 || alu_in2 !== 32'd0) begin
      bad++; $display("FAIL midrst_regs got r13=%0d r3=%0d required 0 0", alu_in1, alu_in2);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_zero_ops();
    test_preload_sub3();
    test_back_to_back();
    test_stall();
    test_illegal_and_r0();
    test_random();
    test_reset_mid_op();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL final_queue got %0d pending required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
